// File: rtl/fft_frame_loader_if.sv
// Sample-in / sample-out bus of the FFT frame loader.
// The master side drives samples upstream and ready downstream; the slave side is the loader.
interface fft_frame_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  smp_vld_i;
    logic [ADDR_WIDTH-1:0] smp_addr_i;
    logic [DATA_WIDTH-1:0] smp_dt_i;
    logic                  out_rdy_i;
    logic                  out_vld_o;
    logic [DATA_WIDTH-1:0] out_dt_o;
    logic [ADDR_WIDTH-1:0] out_idx_o;
    logic                  out_last_o;

    modport master (
        output smp_vld_i, smp_addr_i, smp_dt_i, out_rdy_i,
        input  out_vld_o, out_dt_o, out_idx_o, out_last_o
    );

    modport slave (
        input  smp_vld_i, smp_addr_i, smp_dt_i, out_rdy_i,
        output out_vld_o, out_dt_o, out_idx_o, out_last_o
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Collects one natural-order frame into bit-reversed storage, then drains it
// in index order so the output stream is the FFT input reordering.
module fft_frame_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk_cg_i,
    input  logic                rst_b_i,
    input  logic                clr_i,
    fft_frame_loader_if.slave   bus,
    output logic [7:0]          ovf_cnt_o,
    output logic                seq_err_o
);
    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]            ovf_cnt_q, ovf_cnt_d;
    logic                  seq_err_q, seq_err_d;
    logic [DATA_WIDTH-1:0] mem_q [0:N-1];

    logic                  we_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic                  drop_s;
    logic                  seq_set_s;

    // Next-state: FSM, address tracking, write port, drop/error detection, counters
    always_comb begin
        state_d    = state_q;
        exp_addr_d = exp_addr_q;
        rd_idx_d   = rd_idx_q;
        we_s       = 1'b0;
        waddr_s    = {ADDR_WIDTH{1'b0}};
        drop_s     = 1'b0;
        seq_set_s  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (bus.smp_vld_i) begin
                    if (bus.smp_addr_i == exp_addr_q) begin
                        we_s       = 1'b1;
                        waddr_s    = bitrev(bus.smp_addr_i);
                        exp_addr_d = exp_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        if (bus.smp_addr_i == LAST_ADDR) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        seq_set_s = 1'b1;
                        // Address 0 out of sequence restarts the frame rather than being lost
                        if (bus.smp_addr_i == {ADDR_WIDTH{1'b0}}) begin
                            we_s       = 1'b1;
                            waddr_s    = {ADDR_WIDTH{1'b0}};
                            exp_addr_d = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            exp_addr_d = {ADDR_WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                drop_s = bus.smp_vld_i;
                if (bus.out_rdy_i) begin
                    if (rd_idx_q == LAST_ADDR) begin
                        state_d    = ST_FILL;
                        rd_idx_d   = {ADDR_WIDTH{1'b0}};
                        exp_addr_d = {ADDR_WIDTH{1'b0}};
                    end else begin
                        rd_idx_d = rd_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            default: begin
                state_d    = ST_FILL;
                exp_addr_d = {ADDR_WIDTH{1'b0}};
                rd_idx_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase

        if (clr_i) begin
            ovf_cnt_d = 8'd0;
            seq_err_d = 1'b0;
        end else begin
            if (drop_s && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
            seq_err_d = seq_err_q | seq_set_s;
        end
    end

    // Control and status registers
    always_ff @(posedge clk_cg_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q    <= ST_FILL;
            exp_addr_q <= {ADDR_WIDTH{1'b0}};
            rd_idx_q   <= {ADDR_WIDTH{1'b0}};
            ovf_cnt_q  <= 8'd0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_addr_q <= exp_addr_d;
            rd_idx_q   <= rd_idx_d;
            ovf_cnt_q  <= ovf_cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Frame storage, deliberately not reset; outputs gate it outside DRAIN
    always_ff @(posedge clk_cg_i) begin
        if (we_s) begin
            mem_q[waddr_s] <= bus.smp_dt_i;
        end
    end

    assign bus.out_vld_o  = (state_q == ST_DRAIN);
    assign bus.out_idx_o  = (state_q == ST_DRAIN) ? rd_idx_q : {ADDR_WIDTH{1'b0}};
    assign bus.out_dt_o   = (state_q == ST_DRAIN) ? mem_q[rd_idx_q] : {DATA_WIDTH{1'b0}};
    assign bus.out_last_o = (state_q == ST_DRAIN) && (rd_idx_q == LAST_ADDR);
    assign ovf_cnt_o      = ovf_cnt_q;
    assign seq_err_o      = seq_err_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with an 8-sample frame: reorder,
// backpressure, overflow, sequence errors and reset during drain.
module tb_fft_frame_loader;
    logic       clk_cg_i = 1'b0;
    logic       rst_b_i  = 1'b0;
    logic       clr_i    = 1'b0;
    logic [7:0] ovf_cnt_o;
    logic       seq_err_o;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_seq [0:7];

    fft_frame_loader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    fft_frame_loader #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk_cg_i  (clk_cg_i),
        .rst_b_i   (rst_b_i),
        .clr_i     (clr_i),
        .bus       (bus.slave),
        .ovf_cnt_o (ovf_cnt_o),
        .seq_err_o (seq_err_o)
    );

    always #5 clk_cg_i = ~clk_cg_i;

    task automatic tick();
        @(posedge clk_cg_i);
        #1;
    endtask

    task automatic send(input logic [2:0] a, input logic [7:0] d);
        bus.smp_vld_i  = 1'b1;
        bus.smp_addr_i = a;
        bus.smp_dt_i   = d;
        tick();
        bus.smp_vld_i  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int a = 0; a < 8; a++) send(3'(a), base + 8'(a));
    endtask

    task automatic test_reset();
        bus.smp_vld_i = 1'b0; bus.smp_addr_i = 3'd0; bus.smp_dt_i = 8'd0; bus.out_rdy_i = 1'b0;
        rst_b_i = 1'b0;
        #12;
        tests++;
        if ({bus.out_vld_o, bus.out_last_o, bus.out_dt_o, bus.out_idx_o, ovf_cnt_o, seq_err_o} !== 22'd0) begin
            $display("FAIL reset_outputs: got vld=%b last=%b dt=%h idx=%0d ovf=%0d err=%b, want all 0",
                     bus.out_vld_o, bus.out_last_o, bus.out_dt_o, bus.out_idx_o, ovf_cnt_o, seq_err_o);
            fails++;
        end
        rst_b_i = 1'b1;
        tick();
    endtask

    task automatic test_reorder();
        bus.out_rdy_i = 1'b0;
        send_frame(8'h10);
        bus.out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_dt_o !== exp_seq[i] || bus.out_idx_o !== 3'(i) ||
                bus.out_last_o !== (i == 7)) begin
                $display("FAIL reorder[%0d]: got vld=%b dt=%h idx=%0d last=%b, want vld=1 dt=%h idx=%0d last=%b",
                         i, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o, bus.out_last_o, exp_seq[i], i, (i == 7));
                fails++;
            end
            tick();
        end
        tests++;
        if (bus.out_vld_o !== 1'b0 || bus.out_dt_o !== 8'h00) begin
            $display("FAIL reorder_end: got vld=%b dt=%h, want vld=0 dt=00", bus.out_vld_o, bus.out_dt_o);
            fails++;
        end
        bus.out_rdy_i = 1'b0;
    endtask

    task automatic test_backpressure();
        send_frame(8'h10);
        for (int i = 0; i < 8; i++) begin
            bus.out_rdy_i = 1'b0;
            tick();
            tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_dt_o !== exp_seq[i] || bus.out_idx_o !== 3'(i)) begin
                $display("FAIL bp_hold[%0d]: got vld=%b dt=%h idx=%0d, want vld=1 dt=%h idx=%0d",
                         i, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o, exp_seq[i], i);
                fails++;
            end
            bus.out_rdy_i = 1'b1;
            tick();
        end
        bus.out_rdy_i = 1'b0;
        tests++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL bp_end: got vld=%b after 8 handshakes, want 0", bus.out_vld_o);
            fails++;
        end
    endtask

    task automatic test_overflow();
        send_frame(8'h10);
        bus.out_rdy_i = 1'b0;
        for (int k = 0; k < 3; k++) send(3'd5, 8'hEE);
        tests++;
        if (ovf_cnt_o !== 8'd3 || seq_err_o !== 1'b0) begin
            $display("FAIL ovf_3: got ovf=%0d err=%b, want ovf=3 err=0", ovf_cnt_o, seq_err_o);
            fails++;
        end
        for (int k = 0; k < 297; k++) send(3'd1, 8'hEE);
        tests++;
        if (ovf_cnt_o !== 8'd255) begin
            $display("FAIL ovf_sat: got %0d, want 255", ovf_cnt_o);
            fails++;
        end
        clr_i = 1'b1;
        send(3'd2, 8'hEE);
        clr_i = 1'b0;
        tests++;
        if (ovf_cnt_o !== 8'd0 || bus.out_vld_o !== 1'b1 || bus.out_dt_o !== 8'h10 || bus.out_idx_o !== 3'd0) begin
            $display("FAIL ovf_clr: got ovf=%0d vld=%b dt=%h idx=%0d, want ovf=0 vld=1 dt=10 idx=0",
                     ovf_cnt_o, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o);
            fails++;
        end
        bus.out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.out_rdy_i = 1'b0;
        tests++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL ovf_drain_end: got vld=%b, want 0", bus.out_vld_o);
            fails++;
        end
    endtask

    task automatic test_seq_err();
        logic [7:0] rw_seq [0:7];
        rw_seq = '{8'h40, 8'h34, 8'h32, 8'h36, 8'h31, 8'h35, 8'h33, 8'h37};
        send(3'd0, 8'hA0); send(3'd1, 8'hA1);
        tests++;
        if (seq_err_o !== 1'b0) begin
            $display("FAIL seq_ok_prefix: got err=%b, want 0", seq_err_o);
            fails++;
        end
        send(3'd3, 8'hA3);
        tests++;
        if (seq_err_o !== 1'b1 || bus.out_vld_o !== 1'b0) begin
            $display("FAIL seq_err_set: got err=%b vld=%b, want err=1 vld=0", seq_err_o, bus.out_vld_o);
            fails++;
        end
        send_frame(8'h10);
        bus.out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_dt_o !== exp_seq[i] || bus.out_idx_o !== 3'(i)) begin
                $display("FAIL seq_frame[%0d]: got vld=%b dt=%h idx=%0d, want vld=1 dt=%h idx=%0d",
                         i, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o, exp_seq[i], i);
                fails++;
            end
            tick();
        end
        bus.out_rdy_i = 1'b0;
        tests++;
        if (seq_err_o !== 1'b1) begin
            $display("FAIL seq_sticky: got err=%b, want 1", seq_err_o);
            fails++;
        end
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        send(3'd0, 8'h30); send(3'd1, 8'h31); send(3'd0, 8'h40);
        for (int a = 1; a < 8; a++) send(3'(a), 8'h30 + 8'(a));
        tests++;
        if (seq_err_o !== 1'b1) begin
            $display("FAIL seq_restart_err: got err=%b, want 1", seq_err_o);
            fails++;
        end
        bus.out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_dt_o !== rw_seq[i] || bus.out_idx_o !== 3'(i)) begin
                $display("FAIL seq_restart[%0d]: got vld=%b dt=%h idx=%0d, want vld=1 dt=%h idx=%0d",
                         i, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o, rw_seq[i], i);
                fails++;
            end
            tick();
        end
        bus.out_rdy_i = 1'b0;
        clr_i = 1'b1; tick(); clr_i = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        send_frame(8'h10);
        bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) send(3'd0, 8'hEE);
        tests++;
        if (ovf_cnt_o !== 8'd4 || bus.out_idx_o !== 3'd4 || bus.out_dt_o !== exp_seq[4]) begin
            $display("FAIL mid_drain: got ovf=%0d idx=%0d dt=%h, want ovf=4 idx=4 dt=%h",
                     ovf_cnt_o, bus.out_idx_o, bus.out_dt_o, exp_seq[4]);
            fails++;
        end
        #1 rst_b_i = 1'b0;
        #1;
        tests++;
        if (bus.out_vld_o !== 1'b0 || ovf_cnt_o !== 8'd0 || bus.out_dt_o !== 8'h00 || bus.out_idx_o !== 3'd0) begin
            $display("FAIL rst_drain: got vld=%b ovf=%0d dt=%h idx=%0d, want all 0",
                     bus.out_vld_o, ovf_cnt_o, bus.out_dt_o, bus.out_idx_o);
            fails++;
        end
        rst_b_i = 1'b1;
        bus.out_rdy_i = 1'b0;
        tick();
        send_frame(8'h50);
        bus.out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.out_vld_o !== 1'b1 || bus.out_dt_o !== (exp_seq[i] + 8'h40) || bus.out_idx_o !== 3'(i)) begin
                $display("FAIL post_rst[%0d]: got vld=%b dt=%h idx=%0d, want vld=1 dt=%h idx=%0d",
                         i, bus.out_vld_o, bus.out_dt_o, bus.out_idx_o, exp_seq[i] + 8'h40, i);
                fails++;
            end
            tick();
        end
        bus.out_rdy_i = 1'b0;
    endtask

    initial begin
        exp_seq = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
        test_reset();
        test_reorder();
        test_backpressure();
        test_overflow();
        test_seq_err();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
